// File: rtl/tube_scan_if.sv
// Register-port and display bus for tube_scan_ctrl.
// The master drives the write/read port. The slave drives the readback and the segment/digit strobes.
interface tube_scan_if #(
  parameter int CHANNELS = 3,
  parameter int DIGITS   = 4,
  parameter int ADDR_W   = 3
);
  logic                         we;
  logic [ADDR_W-1:0]            addr;
  logic [31:0]                  wdata;
  logic [31:0]                  rdata;
  logic [8*CHANNELS-1:0]        seg;
  logic [DIGITS*CHANNELS-1:0]   sel;

  modport master (output we, addr, wdata, input rdata, seg, sel);
  modport slave  (input we, addr, wdata, output rdata, seg, sel);
endinterface

// File: rtl/tube_scan_ctrl.sv
// Multi-channel seven-segment scan controller with a shared digit strobe and a one-cycle dead time per slot.
// Defining TUBE_LZB_EN enables per-channel leading-zero blanking.
module tube_scan_lane #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 2
) (
  input  logic [4*DIGITS-1:0] data_i,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic                dead_i,
  output logic [7:0]          seg_o,
  output logic [DIGITS-1:0]   sel_o
);
  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 8'hC0;  4'h1: decode = 8'hF9;
      4'h2: decode = 8'hA4;  4'h3: decode = 8'hB0;
      4'h4: decode = 8'h99;  4'h5: decode = 8'h92;
      4'h6: decode = 8'h82;  4'h7: decode = 8'hF8;
      4'h8: decode = 8'h80;  4'h9: decode = 8'h90;
      4'hA: decode = 8'h88;  4'hB: decode = 8'h83;
      4'hC: decode = 8'hC6;  4'hD: decode = 8'hA1;
      4'hE: decode = 8'h86;  default: decode = 8'h8E;
    endcase
  endfunction

  logic [4*DIGITS-1:0] shifted;
  logic                blank;

  always_comb begin
    // The selected nibble lands in [3:0]. The higher nibbles are still present for the zero test.
    shifted = data_i >> {idx_i, 2'b00};
`ifdef TUBE_LZB_EN
    blank = (idx_i != '0) && (shifted == '0);
`else
    blank = 1'b0;
`endif
    sel_o = '1;
    seg_o = 8'hFF;
    if (!dead_i) begin
      for (int d = 0; d < DIGITS; d++)
        if (idx_i == IDX_W'(d)) sel_o[d] = 1'b0;
      if (!blank) seg_o = decode(shifted[3:0]);
    end
  end
endmodule

module tube_scan_ctrl #(
  parameter int CHANNELS = 3,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int ADDR_W   = 3
) (
  input  logic        clk,
  input  logic        reset,
  tube_scan_if.slave  bus
);
  localparam int PC_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CHANNELS-1:0][4*DIGITS-1:0] data_q;
  logic [PC_W-1:0]                   pcnt_q;
  logic [IDX_W-1:0]                  idx_q;
  logic [8*CHANNELS-1:0]             seg_q, seg_d;
  logic [DIGITS*CHANNELS-1:0]        sel_q, sel_d;
  logic                              dead, tc;
  logic                              unused_wdata;

  assign dead = (pcnt_q == '0);
  assign tc   = (pcnt_q == PC_W'(SCAN_DIV - 1));
  assign unused_wdata = ^bus.wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      pcnt_q <= '0;
      idx_q  <= '0;
      seg_q  <= '1;
      sel_q  <= '1;
    end else begin
      pcnt_q <= tc ? '0 : pcnt_q + PC_W'(1);
      if (tc) idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      seg_q <= seg_d;
      sel_q <= sel_d;
      // Addresses at or beyond CHANNELS match no lane, so those writes fall away.
      for (int c = 0; c < CHANNELS; c++)
        if (bus.we && bus.addr == ADDR_W'(c)) data_q[c] <= bus.wdata[4*DIGITS-1:0];
    end
  end

  always_comb begin
    bus.rdata = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (bus.addr == ADDR_W'(c)) bus.rdata = 32'(data_q[c]);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    tube_scan_lane #(.DIGITS(DIGITS), .IDX_W(IDX_W)) u_lane (
      .data_i (data_q[c]),
      .idx_i  (idx_q),
      .dead_i (dead),
      .seg_o  (seg_d[8*c +: 8]),
      .sel_o  (sel_d[DIGITS*c +: DIGITS])
    );
  end

  assign bus.seg = seg_q;
  assign bus.sel = sel_q;
endmodule
